// File: rtl/pe_pkg.sv
// pe_pkg: opcodes, source codes, config field positions and FSM states shared by the PE operand front end
package pe_pkg;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_SHL = 4'd3, OP_SHR = 4'd4,
                          OP_SRA = 4'd5, OP_OR = 4'd6, OP_XOR = 4'd7, OP_NOR = 4'd8, OP_AND = 4'd9;
   localparam logic [2:0] SRC_N = 3'd0, SRC_E = 3'd1, SRC_S = 3'd2, SRC_W = 3'd3, SRC_IMM = 3'd4, SRC_ACC = 3'd5;
   localparam int OPC_MSB = 18, OPC_LSB = 15, SRC1_MSB = 14, SRC1_LSB = 12, SRC2_MSB = 11, SRC2_LSB = 9;
   typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;
   function automatic logic cfg_legal(input logic [31:0] w);
      return w[OPC_MSB:OPC_LSB] <= OP_AND && w[SRC1_MSB:SRC1_LSB] <= SRC_ACC && w[SRC2_MSB:SRC2_LSB] <= SRC_ACC;
   endfunction
endpackage

// File: rtl/pe_operand_slot.sv
// pe_operand_slot: one operand register with full flag, source mux and neighbour ready generation
module pe_operand_slot
   import pe_pkg::*;
#(
   parameter int DW = 32,
   parameter int NB = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [2:0]       src_i,
   input  logic [NB*DW-1:0] nb_data_i,
   input  logic [NB-1:0]    nb_valid_i,
   input  logic [DW-1:0]    imm_i,
   input  logic [DW-1:0]    acc_i,
   output logic [DW-1:0]    data_o,
   output logic             full_o,
   output logic             full_d_o,
   output logic [NB-1:0]    ready_o
);
   localparam int IW = $clog2(NB);
   logic [IW-1:0] idx;
   logic          is_nb, take, full_q;
   logic [DW-1:0] data_q, data_d;
   assign idx = src_i[IW-1:0];
   always_comb begin
      is_nb        = src_i < SRC_IMM;
      take         = en_i && !full_q && (!is_nb || nb_valid_i[idx]);
      ready_o      = '0;
      ready_o[idx] = en_i && !full_q && is_nb;
      data_d       = !take ? data_q : is_nb ? nb_data_i[idx*DW +: DW] : src_i == SRC_IMM ? imm_i : acc_i;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= !clr_i && (full_q || take);
         data_q <= data_d;
      end
   end
   assign data_o   = data_q;
   assign full_o   = full_q;
   assign full_d_o = full_q || take;
endmodule

// File: rtl/pe_operand_sequencer.sv
// pe_operand_sequencer: gathers two configured operands, issues them to the PE ALU and buffers the result
module pe_operand_sequencer
   import pe_pkg::*;
#(
   parameter int DW = 32,
   parameter int NB = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [31:0]      cfg_word,
   input  logic [DW-1:0]    cfg_imm,
   output logic             cfg_ready,
   output logic             cfg_err,
   input  logic [NB*DW-1:0] nb_data,
   input  logic [NB-1:0]    nb_valid,
   output logic [NB-1:0]    nb_ready,
   output logic [DW-1:0]    alu_in1,
   output logic [DW-1:0]    alu_in2,
   output logic             alu_en,
   output logic [3:0]       alu_op,
   input  logic [DW-1:0]    alu_out,
   output logic [DW-1:0]    res_data,
   output logic             res_valid,
   input  logic             res_ready
);
   state_t        state_q, state_d;
   logic [3:0]    opc_q;
   logic [2:0]    src1_q, src2_q;
   logic [DW-1:0] imm_q, acc_q, res_q, in1_q, in2_q, s1_data, s2_data;
   logic          cfg_err_q, res_valid_q, cfg_ok, cfg_take, collect, fire, f1, f2, f1_d, f2_d;
   logic [NB-1:0] rdy1, rdy2;
   // a config write in COLLECT wins over any neighbour handshake in the same cycle
   always_comb begin
      cfg_ok    = cfg_legal(cfg_word);
      cfg_ready = state_q == IDLE || (state_q == COLLECT && !f1 && !f2);
      cfg_take  = cfg_we && cfg_ready;
      collect   = !rst && !cfg_take && state_q == COLLECT;
      fire      = !rst && state_q == ISSUE && (!res_valid_q || res_ready);
      state_d   = cfg_take ? (cfg_ok ? COLLECT : IDLE) : (collect && f1_d && f2_d) ? ISSUE : fire ? COLLECT : state_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         opc_q       <= '0;
         src1_q      <= '0;
         src2_q      <= '0;
         imm_q       <= '0;
         acc_q       <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         in1_q       <= '0;
         in2_q       <= '0;
      end else begin
         state_q <= state_d;
         if (cfg_take) cfg_err_q <= !cfg_ok;
         if (cfg_take && cfg_ok) {opc_q, src1_q, src2_q, imm_q} <= {cfg_word[OPC_MSB:OPC_LSB], cfg_word[SRC1_MSB:SRC1_LSB], cfg_word[SRC2_MSB:SRC2_LSB], cfg_imm};
         if (state_q == ISSUE) {in1_q, in2_q} <= {s1_data, s2_data};
         if (fire) {res_q, acc_q} <= {alu_out, alu_out};
         res_valid_q <= fire || (res_valid_q && !res_ready);
      end
   end
   pe_operand_slot #(.DW(DW), .NB(NB)) u_slot1 (
      .clk, .rst, .en_i(collect), .clr_i(fire), .src_i(src1_q), .nb_data_i(nb_data), .nb_valid_i(nb_valid),
      .imm_i(imm_q), .acc_i(acc_q), .data_o(s1_data), .full_o(f1), .full_d_o(f1_d), .ready_o(rdy1)
   );
   pe_operand_slot #(.DW(DW), .NB(NB)) u_slot2 (
      .clk, .rst, .en_i(collect), .clr_i(fire), .src_i(src2_q), .nb_data_i(nb_data), .nb_valid_i(nb_valid),
      .imm_i(imm_q), .acc_i(acc_q), .data_o(s2_data), .full_o(f2), .full_d_o(f2_d), .ready_o(rdy2)
   );
   assign nb_ready  = rdy1 | rdy2;
   assign alu_in1   = state_q == ISSUE ? s1_data : in1_q;
   assign alu_in2   = state_q == ISSUE ? s2_data : in2_q;
   assign alu_en    = fire;
   assign alu_op    = opc_q;
   assign res_data  = res_q;
   assign res_valid = res_valid_q;
   assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_pe_operand_sequencer.sv
// tb_pe_operand_sequencer: scoreboard bench with a behavioural ALU and operand-selection model
module tb_pe_operand_sequencer;
   logic         clk = 1'b0, rst = 1'b1, cfg_we = 1'b0, res_ready = 1'b0;
   logic [31:0]  cfg_word = '0, cfg_imm = '0;
   logic [127:0] nb_data = '0;
   logic [3:0]   nb_valid = '0;
   logic         cfg_ready, cfg_err, alu_en, res_valid;
   logic [3:0]   nb_ready, alu_op;
   logic [31:0]  alu_in1, alu_in2, alu_out, res_data;
   int           checks = 0, errors = 0;
   logic [31:0]  exp_q[$];
   logic [31:0]  d[4];
   logic [31:0]  acc_m, imm, e1, e2, er;
   logic [3:0]   op;
   logic [2:0]   s1, s2;
   logic         done;

   pe_operand_sequencer #(.DW(32), .NB(4)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_word(cfg_word), .cfg_imm(cfg_imm),
      .cfg_ready(cfg_ready), .cfg_err(cfg_err), .nb_data(nb_data), .nb_valid(nb_valid),
      .nb_ready(nb_ready), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_en(alu_en), .alu_op(alu_op),
      .alu_out(alu_out), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      case (o)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a * b;
         4'd3: return a << b[4:0];
         4'd4: return a >> b[4:0];
         4'd5: return $signed(a) >>> b[4:0];
         4'd6: return a | b;
         4'd7: return a ^ b;
         4'd8: return ~(a | b);
         default: return a & b;
      endcase
   endfunction

   assign alu_out = alu_f(alu_op, alu_in1, alu_in2);

   function automatic logic [31:0] mk(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b);
      return {13'b0, o, a, b, 9'b0};
   endfunction

   function automatic logic [3:0] rdy_of(input logic [2:0] s);
      return s < 3'd4 ? 4'b0001 << s[1:0] : 4'b0000;
   endfunction

   function automatic logic [31:0] opnd(input logic [2:0] s);
      return s < 3'd4 ? d[s[1:0]] : s == 3'd4 ? imm : acc_m;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input logic [31:0] w, input logic [31:0] im);
      cfg_we = 1'b1;
      cfg_word = w;
      cfg_imm = im;
      @(negedge clk);
      chk("cfg_ready", 32'(cfg_ready), 32'd1);
      tick();
      cfg_we = 1'b0;
   endtask

   always @(negedge clk) begin
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res_unexpected got %h want none", res_data);
         end else chk("res_data_sb", res_data, exp_q.pop_front());
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_cfg_err", 32'(cfg_err), 0);
      chk("rst_cfg_ready", 32'(cfg_ready), 1);
      chk("rst_nb_ready", 32'(nb_ready), 0);
      chk("rst_alu_en", 32'(alu_en), 0);
      chk("rst_alu_op", 32'(alu_op), 0);
      chk("rst_alu_in1", alu_in1, 0);
      chk("rst_alu_in2", alu_in2, 0);
      // N+E add, both tokens in the same cycle
      tick();
      res_ready = 1'b1;
      write_cfg(mk(4'd0, 3'd0, 3'd1), 0);
      nb_data[31:0] = 32'd5;
      nb_data[63:32] = 32'd7;
      nb_valid = 4'b0011;
      exp_q.push_back(32'd12);
      @(negedge clk);
      chk("t1_nb_ready", 32'(nb_ready), 3);
      chk("t1_en_early", 32'(alu_en), 0);
      tick();
      nb_valid = '0;
      @(negedge clk);
      chk("t1_alu_en", 32'(alu_en), 1);
      chk("t1_in1", alu_in1, 5);
      chk("t1_in2", alu_in2, 7);
      chk("t1_op", 32'(alu_op), 0);
      chk("t1_nb_ready_issue", 32'(nb_ready), 0);
      tick();
      @(negedge clk);
      chk("t1_res_valid", 32'(res_valid), 1);
      chk("t1_res_data", res_data, 12);
      chk("t1_en_after", 32'(alu_en), 0);
      chk("t1_in1_hold", alu_in1, 5);
      // W feeds both slots with one token
      tick();
      write_cfg(mk(4'd2, 3'd3, 3'd3), 0);
      nb_data[127:96] = 32'd3;
      nb_valid = 4'b1000;
      exp_q.push_back(32'd9);
      @(negedge clk);
      chk("t3_nb_ready", 32'(nb_ready), 8);
      tick();
      nb_valid = '0;
      @(negedge clk);
      chk("t3_alu_en", 32'(alu_en), 1);
      chk("t3_in1", alu_in1, 3);
      chk("t3_in2", alu_in2, 3);
      tick();
      @(negedge clk);
      chk("t3_res_valid", 32'(res_valid), 1);
      // backpressure then same-cycle drain and issue
      tick();
      res_ready = 1'b0;
      write_cfg(mk(4'd1, 3'd0, 3'd1), 0);
      nb_data[31:0] = 32'd1;
      nb_data[63:32] = 32'd2;
      nb_valid = 4'b0011;
      exp_q.push_back(32'hFFFF_FFFF);
      tick();
      nb_valid = '0;
      @(negedge clk);
      chk("t4_first_issue", 32'(alu_en), 1);
      tick();
      nb_data[31:0] = 32'd30;
      nb_data[63:32] = 32'd20;
      nb_valid = 4'b0011;
      exp_q.push_back(32'd10);
      @(negedge clk);
      chk("t4_nb_ready", 32'(nb_ready), 3);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_stall_en", 32'(alu_en), 0);
         chk("t4_stall_nb_ready", 32'(nb_ready), 0);
         chk("t4_stall_res", res_data, 32'hFFFF_FFFF);
         tick();
      end
      nb_valid = '0;
      res_ready = 1'b1;
      @(negedge clk);
      chk("t4_release_en", 32'(alu_en), 1);
      tick();
      @(negedge clk);
      chk("t4_res_valid", 32'(res_valid), 1);
      chk("t4_res_data", res_data, 10);
      // illegal config words
      tick();
      write_cfg(mk(4'hC, 3'd0, 3'd1), 0);
      nb_valid = 4'b1111;
      @(negedge clk);
      chk("t5_err_op", 32'(cfg_err), 1);
      chk("t5_op_kept", 32'(alu_op), 1);
      chk("t5_nb_ready", 32'(nb_ready), 0);
      chk("t5_alu_en", 32'(alu_en), 0);
      chk("t5_cfg_ready", 32'(cfg_ready), 1);
      tick();
      write_cfg(mk(4'd0, 3'd6, 3'd0), 0);
      @(negedge clk);
      chk("t5_err_src", 32'(cfg_err), 1);
      chk("t5_op_kept2", 32'(alu_op), 1);
      tick();
      nb_valid = '0;
      write_cfg(mk(4'd0, 3'd0, 3'd1), 0);
      @(negedge clk);
      chk("t5_err_clear", 32'(cfg_err), 0);
      chk("t5_op_new", 32'(alu_op), 0);
      // reset with one slot filled and a result pending
      tick();
      res_ready = 1'b0;
      nb_data[31:0] = 32'd4;
      nb_data[63:32] = 32'd4;
      nb_valid = 4'b0011;
      tick();
      nb_valid = '0;
      tick();
      nb_data[31:0] = 32'd9;
      nb_valid = 4'b0001;
      @(negedge clk);
      chk("t6_nb_ready", 32'(nb_ready), 3);
      tick();
      rst = 1'b1;
      nb_valid = 4'b0010;
      @(negedge clk);
      chk("t6_rst_nb_ready", 32'(nb_ready), 0);
      chk("t6_rst_en", 32'(alu_en), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_res_valid", 32'(res_valid), 0);
      chk("t6_res_data", res_data, 0);
      chk("t6_cfg_ready", 32'(cfg_ready), 1);
      for (int i = 0; i < 3; i++) begin
         chk("t6_nb_ready_idle", 32'(nb_ready), 0);
         chk("t6_en_idle", 32'(alu_en), 0);
         @(negedge clk);
      end
      nb_valid = '0;
      // accumulator minus one, wrapping from zero
      tick();
      res_ready = 1'b1;
      write_cfg(mk(4'd1, 3'd5, 3'd4), 1);
      for (int i = 1; i <= 4; i++) exp_q.push_back(32'(0 - i));
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t2_alu_en", 32'(alu_en), 32'(i % 2));
      end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      // randomized operations against the reference model
      acc_m = '0;
      for (int it = 0; it < 30; it++) begin
         op = 4'($urandom_range(0, 9));
         s1 = 3'($urandom_range(0, 5));
         s2 = 3'($urandom_range(0, 5));
         imm = $urandom;
         nb_valid = '0;
         write_cfg(mk(op, s1, s2) | ($urandom & 32'hFFF8_01FF), imm);
         for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            nb_data[i*32 +: 32] = d[i];
         end
         nb_valid = 4'b1111;
         e1 = opnd(s1);
         e2 = opnd(s2);
         er = alu_f(op, e1, e2);
         exp_q.push_back(er);
         acc_m = er;
         done = 1'b0;
         for (int c = 0; c < 40 && !done; c++) begin
            res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c == 0) chk("rnd_nb_ready", 32'(nb_ready), 32'(rdy_of(s1) | rdy_of(s2)));
            if (alu_en) begin
               chk("rnd_in1", alu_in1, e1);
               chk("rnd_in2", alu_in2, e2);
               chk("rnd_op", 32'(alu_op), 32'(op));
               done = 1'b1;
            end
            tick();
         end
         chk("rnd_issued", 32'(done), 1);
         nb_valid = '0;
      end
      res_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
      @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
